// File: rtl/adc_twin_pkg.sv
// Shared state encoding and frame constants for the ADC twin responder.
// Frame: start bit, CFG_BITS control bits, null bit, ADC_DATA_W data bits, optional TAIL_BITS tail.
package adc_twin_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int CFG_BITS   = 3;
    localparam int TAIL_BITS  = 11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CFG,
        NULL,
        DATA,
        TAIL,
        DRAIN
    } state_t;

endpackage

// File: rtl/adc_twin_sync_edge.sv
// N-stage synchronizer with registered level and rise/fall pulses.
// Latency: pulses and level appear STAGES+1 clk after the pin edge.
// Backpressure: none; free-running sampler.
module adc_twin_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // Extra prev stage keeps level and pulses time-aligned for the consumer.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
        fall_d = ~sync_q[STAGES-1] & prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign lvl  = prev_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/adc_twin_responder.sv
// SPI-slave twin of the 2-channel ADC; ADC_TWIN_FAULT_EN adds stuck-at bit injection.
// Latency: miso updates SYNC_STAGES+2 clk after each sclk falling pin edge.
// Backpressure: none; the reader owns sclk pacing, cs_n rise aborts or completes a frame.
module adc_twin_responder
    import adc_twin_pkg::*;
#(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] ch0_val,
    input  logic [DATA_W-1:0] ch1_val,
`ifdef ADC_TWIN_FAULT_EN
    input  logic [DATA_W-1:0] fault_mask,
    input  logic [DATA_W-1:0] fault_val,
`endif
    output logic              cfg_sgl,
    output logic              cfg_odd,
    output logic              cfg_msbf,
    output logic [DATA_W-1:0] held_word,
    output logic              xfer_done,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W);

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise_raw, sclk_fall_raw;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic sclk_rise, sclk_fall;
    logic unused_edges;

    adc_twin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk  (clk),
        .rst  (rst),
        .din  (cs_n),
        .lvl  (cs_lvl),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    adc_twin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .lvl  (sclk_lvl),
        .rise (sclk_rise_raw),
        .fall (sclk_fall_raw)
    );

    adc_twin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk  (clk),
        .rst  (rst),
        .din  (mosi),
        .lvl  (mosi_lvl),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    // sclk only counts while the reader holds chip select.
    assign sclk_rise    = sclk_rise_raw & ~cs_lvl;
    assign sclk_fall    = sclk_fall_raw & ~cs_lvl;
    assign unused_edges = sclk_lvl ^ mosi_rise ^ mosi_fall;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] ch0_cap_q, ch0_cap_d;
    logic [DATA_W-1:0] ch1_cap_q, ch1_cap_d;
    logic [DATA_W-1:0] held_q, held_d;
    logic              sgl_q, sgl_d;
    logic              odd_q, odd_d;
    logic              msbf_q, msbf_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] sel_word;
    logic [DATA_W-1:0] final_word;

    // Differential modes saturate at zero instead of wrapping.
    always_comb begin
        sel_word = ch0_cap_q;
        if (sgl_q) begin
            sel_word = odd_q ? ch1_cap_q : ch0_cap_q;
        end else if (!odd_q) begin
            sel_word = (ch0_cap_q > ch1_cap_q) ? (ch0_cap_q - ch1_cap_q) : '0;
        end else begin
            sel_word = (ch1_cap_q > ch0_cap_q) ? (ch1_cap_q - ch0_cap_q) : '0;
        end
    end

`ifdef ADC_TWIN_FAULT_EN
    assign final_word = (sel_word & ~fault_mask) | (fault_val & fault_mask);
`else
    assign final_word = sel_word;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch0_cap_d = ch0_cap_q;
        ch1_cap_d = ch1_cap_q;
        held_d    = held_q;
        sgl_d     = sgl_q;
        odd_d     = odd_q;
        msbf_d    = msbf_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (cs_rise && (state_q != IDLE)) begin
            // End of frame wins over any sclk edge seen in the same clk.
            state_d = IDLE;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
            if (state_q == DRAIN) begin
                done_d = 1'b1;
            end else if (state_q != WAIT_START) begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (sclk_rise && mosi_lvl) begin
                        ch0_cap_d = ch0_val;
                        ch1_cap_d = ch1_val;
                        held_d    = ch0_val;
                        cnt_d     = '0;
                        state_d   = CFG;
                    end
                end
                CFG: begin
                    if (sclk_rise) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(0)) begin
                            sgl_d = mosi_lvl;
                        end else if (cnt_q == CNT_W'(1)) begin
                            odd_d = mosi_lvl;
                        end else if (cnt_q == CNT_W'(CFG_BITS - 1)) begin
                            msbf_d  = mosi_lvl;
                            held_d  = final_word;
                            state_d = NULL;
                        end
                    end
                end
                NULL: begin
                    if (sclk_fall) begin
                        oe_d    = 1'b1;
                        miso_d  = 1'b0;
                        cnt_d   = CNT_W'(DATA_W - 1);
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        miso_d = held_q[cnt_q];
                        if (cnt_q == '0) begin
                            cnt_d   = CNT_W'(1);
                            state_d = msbf_q ? DRAIN : TAIL;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                TAIL: begin
                    if (sclk_fall) begin
                        miso_d = held_q[cnt_q];
                        if (cnt_q == CNT_W'(TAIL_BITS)) begin
                            state_d = DRAIN;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (sclk_fall) begin
                        miso_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ch0_cap_q <= '0;
            ch1_cap_q <= '0;
            held_q    <= '0;
            sgl_q     <= 1'b0;
            odd_q     <= 1'b0;
            msbf_q    <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch0_cap_q <= ch0_cap_d;
            ch1_cap_q <= ch1_cap_d;
            held_q    <= held_d;
            sgl_q     <= sgl_d;
            odd_q     <= odd_d;
            msbf_q    <= msbf_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = oe_q;
    assign cfg_sgl   = sgl_q;
    assign cfg_odd   = odd_q;
    assign cfg_msbf  = msbf_q;
    assign held_word = held_q;
    assign xfer_done = done_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_adc_twin_responder.sv
// Bench for adc_twin_responder: acts as the SPI reader, scoreboards the miso stream.
// Fault-injection scenario runs only when ADC_TWIN_FAULT_EN is defined.
module tb_adc_twin_responder;

    localparam int W    = 12;
    localparam int HALF = 8;

    logic         clk = 1'b0;
    logic         rst, cs_n, sclk, mosi;
    logic         miso, miso_oe;
    logic [W-1:0] ch0_val, ch1_val;
    logic         cfg_sgl, cfg_odd, cfg_msbf;
    logic [W-1:0] held_word;
    logic         xfer_done, frame_err;
`ifdef ADC_TWIN_FAULT_EN
    logic [W-1:0] fault_mask, fault_val;
`endif

    always #10 clk = ~clk;

    adc_twin_responder dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .ch0_val   (ch0_val),
        .ch1_val   (ch1_val),
`ifdef ADC_TWIN_FAULT_EN
        .fault_mask(fault_mask),
        .fault_val (fault_val),
`endif
        .cfg_sgl   (cfg_sgl),
        .cfg_odd   (cfg_odd),
        .cfg_msbf  (cfg_msbf),
        .held_word (held_word),
        .xfer_done (xfer_done),
        .frame_err (frame_err)
    );

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];
    int   done_cnt = 0;
    int   err_cnt  = 0;
    logic oe_at_err = 1'b1;
    int   done0, err0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (xfer_done) done_cnt++;
        if (frame_err) begin
            err_cnt++;
            oe_at_err = miso_oe;
        end
    end

    task automatic half_sclk();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic ctrl_bit(input logic b);
        mosi = b;
        half_sclk();
        sclk = 1'b1;
        half_sclk();
        sclk = 1'b0;
    endtask

    // mode 0: end with cs_n rise; mode 1: assert rst mid-frame instead.
    task automatic run_frame(input string nm, input int zeros, input logic sgl, input logic odd,
                             input logic msbf, input logic [W-1:0] word, input int nsamp,
                             input int mode);
        logic stream[$];
        logic exp_bit;
        stream.push_back(1'b0);
        for (int i = W - 1; i >= 0; i--) stream.push_back(word[i]);
        if (!msbf) for (int i = 1; i < W; i++) stream.push_back(word[i]);
        stream.push_back(1'b0);
        for (int i = 0; i < nsamp && i < stream.size(); i++) exp_q.push_back(stream[i]);

        done0 = done_cnt;
        err0  = err_cnt;
        cs_n  = 1'b0;
        half_sclk();
        for (int z = 0; z < zeros; z++) ctrl_bit(1'b0);
        ctrl_bit(1'b1);
        ctrl_bit(sgl);
        ctrl_bit(odd);
        ctrl_bit(msbf);
        mosi = 1'b0;
        for (int k = 0; k < nsamp; k++) begin
            half_sclk();
            chk($sformatf("%s oe[%0d]", nm, k), miso_oe, 1);
            exp_bit = exp_q.pop_front();
            chk($sformatf("%s miso[%0d]", nm, k), miso, exp_bit);
            sclk = 1'b1;
            half_sclk();
            sclk = 1'b0;
        end
        if (mode == 0) begin
            half_sclk();
            cs_n = 1'b1;
        end else begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk({nm, " rst oe"}, miso_oe, 0);
            chk({nm, " rst held"}, held_word, 0);
            chk({nm, " rst sgl"}, cfg_sgl, 0);
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
                half_sclk();
                sclk = 1'b1;
                half_sclk();
                sclk = 1'b0;
                chk($sformatf("%s post-rst oe[%0d]", nm, k), miso_oe, 0);
            end
            half_sclk();
            cs_n = 1'b1;
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic post_checks(input string nm, input int exp_done, input int exp_err,
                               input logic [W-1:0] word, input logic sgl, input logic odd,
                               input logic msbf);
        chk({nm, " xfer_done"}, done_cnt - done0, exp_done);
        chk({nm, " frame_err"}, err_cnt - err0, exp_err);
        chk({nm, " held_word"}, held_word, word);
        chk({nm, " cfg"}, {cfg_sgl, cfg_odd, cfg_msbf}, {sgl, odd, msbf});
        chk({nm, " idle oe"}, miso_oe, 0);
        chk({nm, " idle miso"}, miso, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        cs_n    = 1'b1;
        sclk    = 1'b0;
        mosi    = 1'b0;
        ch0_val = '0;
        ch1_val = '0;
`ifdef ADC_TWIN_FAULT_EN
        fault_mask = '0;
        fault_val  = '0;
`endif
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset miso", miso, 0);
        chk("reset oe", miso_oe, 0);
        chk("reset cfg", {cfg_sgl, cfg_odd, cfg_msbf}, 0);
        chk("reset held", held_word, 0);
        chk("reset done", xfer_done, 0);
        chk("reset err", frame_err, 0);
        repeat (10) @(negedge clk);

        ch0_val = 12'hA5C;
        ch1_val = 12'h3C3;
        run_frame("ch0", 0, 1'b1, 1'b0, 1'b1, 12'hA5C, 14, 0);
        post_checks("ch0", 1, 0, 12'hA5C, 1'b1, 1'b0, 1'b1);

        ch1_val = 12'h123;
        run_frame("ch1 lsbf", 0, 1'b1, 1'b1, 1'b0, 12'h123, 25, 0);
        post_checks("ch1 lsbf", 1, 0, 12'h123, 1'b1, 1'b1, 1'b0);

        ch0_val = 12'h100;
        ch1_val = 12'h180;
        run_frame("diff0", 0, 1'b0, 1'b0, 1'b1, 12'h000, 14, 0);
        post_checks("diff0", 1, 0, 12'h000, 1'b0, 1'b0, 1'b1);
        run_frame("diff1", 0, 1'b0, 1'b1, 1'b1, 12'h080, 14, 0);
        post_checks("diff1", 1, 0, 12'h080, 1'b0, 1'b1, 1'b1);

        ch0_val = 12'hA5C;
        ch1_val = 12'h3C3;
        run_frame("zeros", 3, 1'b1, 1'b0, 1'b1, 12'hA5C, 14, 0);
        post_checks("zeros", 1, 0, 12'hA5C, 1'b1, 1'b0, 1'b1);

        oe_at_err = 1'b1;
        run_frame("abort", 0, 1'b1, 1'b0, 1'b1, 12'hA5C, 6, 0);
        post_checks("abort", 0, 1, 12'hA5C, 1'b1, 1'b0, 1'b1);
        chk("abort oe at err", oe_at_err, 0);
        run_frame("after abort", 0, 1'b1, 1'b0, 1'b1, 12'hA5C, 14, 0);
        post_checks("after abort", 1, 0, 12'hA5C, 1'b1, 1'b0, 1'b1);

        run_frame("rst mid", 0, 1'b1, 1'b0, 1'b1, 12'hA5C, 4, 1);
        post_checks("rst mid", 0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
        run_frame("after rst", 0, 1'b1, 1'b0, 1'b1, 12'hA5C, 14, 0);
        post_checks("after rst", 1, 0, 12'hA5C, 1'b1, 1'b0, 1'b1);

`ifdef ADC_TWIN_FAULT_EN
        fault_mask = 12'h001;
        fault_val  = 12'h001;
        ch0_val    = 12'h000;
        run_frame("fault", 0, 1'b1, 1'b0, 1'b1, 12'h001, 14, 0);
        post_checks("fault", 1, 0, 12'h001, 1'b1, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
